// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch front end.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0,x0,0 -- presented to decode whenever no instruction is valid
    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/ready handshake.
interface fetch_stage_if;
    import riscv_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} holding register used while decode is stalled.
module fetch_skid_buffer
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            drain,
    input  logic            flush,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic            full
);

    // Capture a fetched word on load; drain or flush empties the entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full  <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else begin
            if (flush || drain) begin
                full <= 1'b0;
            end else if (load) begin
                full <= 1'b1;
            end
            if (load) begin
                instr <= instr_in;
                pc    <= pc_in;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, memory request FSM and decoder output register.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic             clk,
    input  logic             rst,
    fetch_stage_if.master    imem,
    input  logic             stall,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             if_valid,
    output logic [XLEN-1:0]  if_instr,
    output logic [XLEN-1:0]  if_pc
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] target;
    logic            req;
    logic [XLEN-1:0] addr;

    logic            ack;
    logic            consume;
    logic            slot_free;

    logic            skid_load;
    logic            skid_drain;
    logic [XLEN-1:0] skid_instr;
    logic [XLEN-1:0] skid_pc;
    logic            skid_full;

    assign imem.imem_req  = req;
    assign imem.imem_addr = addr;

    assign pc_next   = pc + 32'd4;
    assign target    = {redirect_pc[XLEN-1:2], 2'b00};
    assign ack       = req && imem.imem_ready;
    assign consume   = if_valid && !stall;
    assign slot_free = !if_valid || consume;

    assign skid_load  = (state == FETCH) && ack && !slot_free && !redirect;
    assign skid_drain = (state == HOLD) && consume && !redirect;

    fetch_skid_buffer u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .drain    (skid_drain),
        .flush    (redirect),
        .instr_in (imem.imem_rdata),
        .pc_in    (pc),
        .instr    (skid_instr),
        .pc       (skid_pc),
        .full     (skid_full)
    );

    // FSM, PC, registered request/address and decoder output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            req      <= 1'b0;
            addr     <= RESET_PC;
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
            if_pc    <= '0;
        end else if (redirect) begin
            pc       <= target;
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
            // An unanswered request (FETCH or DROP) must still complete at its
            // old address; once it has, fetching resumes at the new target.
            if ((state != HOLD) && req && !ack) begin
                state <= DROP;
            end else begin
                state <= FETCH;
                req   <= 1'b1;
                addr  <= target;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (ack) begin
                        pc <= pc_next;
                        if (slot_free) begin
                            if_valid <= 1'b1;
                            if_instr <= imem.imem_rdata;
                            if_pc    <= pc;
                            addr     <= pc_next;
                        end else begin
                            state <= HOLD;
                            req   <= 1'b0;
                        end
                    end else begin
                        req  <= 1'b1;
                        addr <= pc;
                        if (consume) begin
                            if_valid <= 1'b0;
                            if_instr <= NOP_INSTR;
                        end
                    end
                end
                HOLD: begin
                    if (consume) begin
                        if_valid <= 1'b1;
                        if_instr <= skid_instr;
                        if_pc    <= skid_pc;
                        state    <= FETCH;
                        req      <= 1'b1;
                        addr     <= pc;
                    end
                end
                DROP: begin
                    if (ack) begin
                        state <= FETCH;
                        addr  <= pc;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; memory echoes the address as data.
module tb_fetch_stage;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic        ready;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int unsigned n_checks;
    int unsigned n_errors;

    fetch_stage_if bus ();

    assign bus.imem_rdata = bus.imem_addr;
    assign bus.imem_ready = ready;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (bus),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        ready       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        #12;
        check("rst_req",   32'(bus.imem_req), 32'd0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_instr", if_instr, 32'h0000_0013);
        check("rst_pc",    if_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // 1: streaming with ready tied high
        tick();
        check("t1_req",    32'(bus.imem_req), 32'd1);
        check("t1_addr0",  bus.imem_addr, 32'h0);
        check("t1_nvalid", 32'(if_valid), 32'd0);
        tick();
        check("t1_valid0", 32'(if_valid), 32'd1);
        check("t1_pc0",    if_pc, 32'h0);
        check("t1_instr0", if_instr, 32'h0);
        tick();
        check("t1_pc4",    if_pc, 32'h4);
        check("t1_instr4", if_instr, 32'h4);

        // 2: stall while the word at pc 8 arrives
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_hold_pc",  if_pc, 32'h4);
            check("t2_hold_val", 32'(if_valid), 32'd1);
            check("t2_hold_req", 32'(bus.imem_req), 32'd0);
        end
        check("t2_skid_full", 32'(dut.u_skid.full), 32'd1);
        stall = 1'b0;
        tick();
        check("t2_pc8",    if_pc, 32'h8);
        check("t2_instr8", if_instr, 32'h8);
        check("t2_addr12", bus.imem_addr, 32'hC);
        tick();
        check("t2_pc12",   if_pc, 32'hC);
        check("t2_valid",  32'(if_valid), 32'd1);

        // 3: memory answers 0x10 three cycles late
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_addr",  bus.imem_addr, 32'h10);
            check("t3_req",   32'(bus.imem_req), 32'd1);
            check("t3_valid", 32'(if_valid), 32'd0);
            check("t3_nop",   if_instr, 32'h0000_0013);
        end
        ready = 1'b1;
        tick();
        check("t3_pc10",  if_pc, 32'h10);
        check("t3_val10", 32'(if_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_stream", if_pc, 32'h14 + 32'(4 * i));
        end

        // 4: redirect to 0x203 while the 0x20 request is unanswered
        check("t4_pend_addr", bus.imem_addr, 32'h20);
        ready       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        tick();
        redirect = 1'b0;
        check("t4_state_drop", 32'(dut.state), 32'(DROP));
        check("t4_stale_addr", bus.imem_addr, 32'h20);
        check("t4_req",        32'(bus.imem_req), 32'd1);
        check("t4_valid",      32'(if_valid), 32'd0);
        tick();
        check("t4_stale_addr2", bus.imem_addr, 32'h20);
        ready = 1'b1;
        tick();
        check("t4_discard",  32'(if_valid), 32'd0);
        check("t4_new_addr", bus.imem_addr, 32'h200);
        tick();
        check("t4_pc200",    if_pc, 32'h200);
        check("t4_instr200", if_instr, 32'h200);
        check("t4_val200",   32'(if_valid), 32'd1);

        // 5: redirect together with stall while the skid is occupied
        stall = 1'b1;
        tick();
        check("t5_skid_full", 32'(dut.u_skid.full), 32'd1);
        check("t5_hold_pc",   if_pc, 32'h200);
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        check("t5_valid",     32'(if_valid), 32'd0);
        check("t5_skid_empty", 32'(dut.u_skid.full), 32'd0);
        check("t5_addr",      bus.imem_addr, 32'h300);
        check("t5_req",       32'(bus.imem_req), 32'd1);
        tick();
        check("t5_pc300",     if_pc, 32'h300);
        check("t5_val300",    32'(if_valid), 32'd1);

        // 6: wrap at the top of the address space, then async reset
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        check("t6_valid",   32'(if_valid), 32'd0);
        check("t6_addr",    bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        check("t6_pc_top",  if_pc, 32'hFFFF_FFFC);
        check("t6_val_top", 32'(if_valid), 32'd1);
        tick();
        check("t6_pc_wrap", if_pc, 32'h0);
        check("t6_addr4",   bus.imem_addr, 32'h4);
        #3;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(if_valid), 32'd0);
        check("t6_rst_pc",    dut.pc, 32'h0);
        check("t6_rst_req",   32'(bus.imem_req), 32'd0);
        check("t6_rst_instr", if_instr, 32'h0000_0013);
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        check("t6_restart_pc",  if_pc, 32'h0);
        check("t6_restart_val", 32'(if_valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage directly upstream of the instruction decoder. Holds the PC and issues word requests to instruction memory over a req/ready handshake. Presents one registered instruction/PC pair per cycle to the decoder, with a one-entry skid buffer for decode stalls and a flush/redirect path for taken branches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; low 2 bits must be 0.
NOP_INSTR, 32'h0000_0013, value driven on if_instr when no valid instruction (addi x0,x0,0).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  byte address of request, word aligned
imem_rdata  input  32  instruction word, valid in the cycle imem_ready=1
imem_ready  input  1  completes the outstanding request this cycle
stall  input  1  decoder cannot accept the instruction this cycle
redirect  input  1  taken branch/jump: flush and refetch
redirect_pc  input  32  new PC; bits [1:0] ignored and forced to 0
if_valid  output  1  if_instr/if_pc hold a valid instruction
if_instr  output  32  instruction to decoder
if_pc  output  32  address of if_instr

Behaviour:
- Reset (async, active-high): pc=RESET_PC, state=FETCH, if_valid=0, if_instr=NOP_INSTR, if_pc=0, skid empty, imem_req=0 while rst=1.
- Output register consumed when if_valid=1 and stall=0. Slot is free when if_valid=0 or it is being consumed.
- Memory rule: once imem_req=1, imem_req and imem_addr stay stable until imem_ready=1. imem_ready while imem_req=0 is ignored.
- States: FETCH, HOLD, DROP.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ready with slot free: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4, stay in FETCH.
  - On imem_ready with slot blocked: store {rdata, pc} in skid, pc<=pc+4, go to HOLD.
  - No imem_ready with slot consumed: if_valid<=0, if_instr<=NOP_INSTR.
- HOLD:
  - imem_req=0.
  - When the slot is consumed: output register loads from skid, skid is emptied, go to FETCH.
- DROP:
  - imem_req=1, imem_addr=stale address from the aborted request.
  - On imem_ready: discard the data, go to FETCH with the redirected pc.
- Redirect has highest priority in every state and overrides stall.
  - Effect: pc<=redirect_pc&~3, if_valid<=0, if_instr<=NOP_INSTR, skid emptied.
  - If in FETCH with imem_ready=0, go to DROP; the stale request must complete first.
  - If in FETCH with imem_ready=1, discard the data and stay in FETCH.
  - If in HOLD or DROP, go to FETCH or stay in DROP respectively. A repeated redirect in DROP just updates pc.
- Latency: imem_ready tied high gives one instruction per cycle; if_valid rises at the edge ending the first imem_req cycle.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Reset mid-transaction: the outstanding request is abandoned; the memory must tolerate imem_req dropping during reset.

Decomposition:
- Shared package riscv_pkg holds:
  - NOP_INSTR and the default RESET_PC constants.
  - The fetch state enum {FETCH, HOLD, DROP}.
  - XLEN=32.
- One sub-module, fetch_skid_buffer: a one-entry {instr, pc} register with load, drain, flush and full flag.
- The PC, FSM and output register stay in fetch_stage.

Test Plan:
1. Reset release, imem_ready=1, stall=0, memory returns addr as data:
   - Required: if_pc 0,4,8,12 on consecutive cycles, if_valid=1 from the first edge after imem_req, no bubbles.
2. Stall=1 for 3 cycles while the word at pc 8 arrives:
   - Required: if_pc=4 held, imem_req=0 during HOLD.
   - Required: after stall drops, if_pc=8 then 12, no instruction lost or duplicated.
3. imem_ready delayed 3 cycles:
   - Required: imem_addr=0x10 stable throughout, if_valid=0 with if_instr=0x00000013 until the data arrives.
4. Redirect to 0x203 while a request to 0x20 is pending (ready=0):
   - Required: DROP entered and the 0x20 data discarded.
   - Required: the next request has imem_addr=0x200, and the first valid if_pc=0x200.
5. Redirect and stall asserted together with if_valid=1:
   - Required: if_valid=0 next cycle and the skid is cleared.
   - Required: the following fetch is at redirect_pc.
6. Redirect to 0xFFFF_FFFC with ready=1:
   - Required: if_pc sequence 0xFFFF_FFFC, 0x0000_0000.
   - Required: an async rst pulse mid-stream forces if_valid=0 and pc=RESET_PC immediately.
